// File: rtl/rr_arbiter8_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter8_pkg
//  Description : Shared constants for the 8-way round-robin arbiter:
//                FSM state encoding, requester count and index width.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package rr_arbiter8_pkg;

   // FSM state encoding
   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] GRANT = 1'b1;

   // Requester geometry
   localparam int NUM_REQ = 8;
   localparam int IDX_W   = 3;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter8_onehot_dec3to8.sv
`default_nettype none
// ============================================================================
//  Module      : onehot_dec3to8
//  Description : Combinational binary-to-one-hot decoder,
//                000 -> 0000_0001 ... 111 -> 1000_0000.
//  Ports       : idx    [2:0] in  - binary index
//                onehot [7:0] out - one-hot decode of idx
//  Revision    : 1.0 - initial release
// ============================================================================
module onehot_dec3to8
   import rr_arbiter8_pkg::*;
(
   input  logic [IDX_W-1:0]   idx,
   output logic [NUM_REQ-1:0] onehot
);

   assign onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << idx;

endmodule
`default_nettype wire

// File: rtl/rr_arbiter8.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter8
//  Description : 8-requester round-robin arbiter with registered one-hot
//                grant, owner release, request-drop detection and a
//                MAX_HOLD revocation timer. At least one dead cycle always
//                separates two owners.
//  Ports       : clk          in  - clock, rising edge
//                rst_n        in  - synchronous active-low reset
//                req    [7:0] in  - request per requester
//                rel          in  - release pulse from the current owner
//                                   ("release" is a reserved word)
//                grant  [7:0] out - registered one-hot grant
//                grant_idx[2:0] out - binary owner index (valid with grant_valid)
//                grant_valid  out - grant is non-zero
//                timeout      out - one-cycle pulse on MAX_HOLD revocation
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter8
   import rr_arbiter8_pkg::*;
#(
   parameter int MAX_HOLD = 16
)(
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_REQ-1:0] req,
   input  logic               rel,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   grant_idx,
   output logic               grant_valid,
   output logic               timeout
);

   logic [0:0]         r_state;
   logic [NUM_REQ-1:0] r_grant;
   logic [IDX_W-1:0]   r_idx;
   logic               r_valid;
   logic               r_timeout;
   logic [7:0]         r_hold;
   logic [IDX_W-1:0]   r_last;

   logic               w_found;
   logic [IDX_W-1:0]   w_pick;
   logic [NUM_REQ-1:0] w_onehot;
   logic               w_hold_max;
   logic               w_end;
   logic               w_to;

   // Round-robin scan starting at last+1. The loop walks from the lowest
   // priority candidate (last itself) to the highest (last+1), so the final
   // overwrite is the winner.
   always_comb begin
      logic [IDX_W-1:0] w_cand;
      w_found = 1'b0;
      w_pick  = '0;
      w_cand  = '0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         w_cand = r_last + IDX_W'(k);
         if (req[w_cand]) begin
            w_found = 1'b1;
            w_pick  = w_cand;
         end
      end
   end

   onehot_dec3to8 u_dec (
      .idx    (w_pick),
      .onehot (w_onehot)
   );

   assign w_hold_max = (r_hold == 8'(MAX_HOLD));
   assign w_end      = rel | ~req[r_idx] | w_hold_max;
   // Timeout only when the hold limit is the sole cause of the end
   assign w_to       = w_hold_max & ~rel & req[r_idx];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_grant   <= '0;
         r_idx     <= '0;
         r_valid   <= 1'b0;
         r_timeout <= 1'b0;
         r_hold    <= '0;
         r_last    <= IDX_W'(NUM_REQ - 1);
      end else begin
         r_timeout <= 1'b0;
         if (r_state == IDLE) begin
            if (w_found) begin
               r_state <= GRANT;
               r_grant <= w_onehot;
               r_idx   <= w_pick;
               r_valid <= 1'b1;
               r_last  <= w_pick;
               r_hold  <= 8'd1;
            end
         end else begin
            if (w_end) begin
               r_state   <= IDLE;
               r_grant   <= '0;
               r_valid   <= 1'b0;
               r_hold    <= '0;
               r_timeout <= w_to;
            end else begin
               r_hold <= r_hold + 8'd1;
            end
         end
      end
   end

   assign grant       = r_grant;
   assign grant_idx   = r_idx;
   assign grant_valid = r_valid;
   assign timeout     = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter8.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rr_arbiter8
//  Description : Directed self-checking bench for rr_arbiter8 (MAX_HOLD=4).
//  Ports       : none
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_arbiter8;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] req;
   logic       rel;
   logic [7:0] grant;
   logic [2:0] grant_idx;
   logic       grant_valid;
   logic       timeout;

   int nvec = 0;
   int nerr = 0;

   rr_arbiter8 #(.MAX_HOLD(4)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req         (req),
      .rel         (rel),
      .grant       (grant),
      .grant_idx   (grant_idx),
      .grant_valid (grant_valid),
      .timeout     (timeout)
   );

   always #5 clk = ~clk;

   // Advance one edge; outputs are sampled and inputs changed 1 time unit later
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; req = 8'h00; rel = 1'b0;
      cyc(); cyc();
      nvec++; if (grant !== 8'h00) begin nerr++; $display("FAIL reset_grant: got %h want 00", grant); end
      nvec++; if (grant_idx !== 3'd0) begin nerr++; $display("FAIL reset_idx: got %0d want 0", grant_idx); end
      nvec++; if (grant_valid !== 1'b0) begin nerr++; $display("FAIL reset_valid: got %b want 0", grant_valid); end
      nvec++; if (timeout !== 1'b0) begin nerr++; $display("FAIL reset_timeout: got %b want 0", timeout); end
   endtask

   // req=FF from the first cycle out of reset: 0,1,...,7,0 each ended by release
   task automatic test_reset_priority();
      logic [7:0] exp_g;
      rst_n = 1'b1; req = 8'hFF;
      for (int k = 0; k < 9; k++) begin
         cyc();
         exp_g = 8'h01 << (k % 8);
         nvec++; if (grant !== exp_g || grant_idx !== 3'(k % 8) || grant_valid !== 1'b1)
            begin nerr++; $display("FAIL rp_grant[%0d]: got %h/%0d/%b want %h/%0d/1", k, grant, grant_idx, grant_valid, exp_g, k % 8); end
         rel = 1'b1;
         cyc();
         rel = 1'b0;
         nvec++; if (grant !== 8'h00 || grant_valid !== 1'b0 || timeout !== 1'b0)
            begin nerr++; $display("FAIL rp_dead[%0d]: got %h/%b/%b want 00/0/0", k, grant, grant_valid, timeout); end
      end
      req = 8'h00;
      cyc();
   endtask

   // last=6, then req has bits 6 and 0 -> 0 wins
   task automatic test_wrap();
      req = 8'h40;
      cyc();
      nvec++; if (grant_idx !== 3'd6 || grant !== 8'h40) begin nerr++; $display("FAIL wrap_setup: got %h/%0d want 40/6", grant, grant_idx); end
      req = 8'b0100_0001; rel = 1'b1;
      cyc();
      rel = 1'b0;
      nvec++; if (grant !== 8'h00) begin nerr++; $display("FAIL wrap_dead: got %h want 00", grant); end
      cyc();
      nvec++; if (grant_idx !== 3'd0 || grant !== 8'h01) begin nerr++; $display("FAIL wrap_idx: got %h/%0d want 01/0", grant, grant_idx); end
      req = 8'h00;
      cyc(); cyc();
      nvec++; if (grant_valid !== 1'b0) begin nerr++; $display("FAIL wrap_idle: got %b want 0", grant_valid); end
   endtask

   // MAX_HOLD=4: 4 grant cycles, then dead cycle with timeout, then re-grant
   task automatic test_timeout();
      req = 8'h04;
      cyc();
      for (int i = 0; i < 4; i++) begin
         nvec++; if (grant !== 8'h04 || timeout !== 1'b0)
            begin nerr++; $display("FAIL to_hold[%0d]: got %h/%b want 04/0", i, grant, timeout); end
         cyc();
      end
      nvec++; if (grant !== 8'h00 || grant_valid !== 1'b0 || timeout !== 1'b1)
         begin nerr++; $display("FAIL to_pulse: got %h/%b/%b want 00/0/1", grant, grant_valid, timeout); end
      cyc();
      nvec++; if (grant !== 8'h04 || grant_idx !== 3'd2 || timeout !== 1'b0)
         begin nerr++; $display("FAIL to_regrant: got %h/%0d/%b want 04/2/0", grant, grant_idx, timeout); end
      rel = 1'b1;
      cyc();
      rel = 1'b0; req = 8'h00;
      nvec++; if (grant !== 8'h00 || timeout !== 1'b0) begin nerr++; $display("FAIL to_rel: got %h/%b want 00/0", grant, timeout); end
      cyc();
   endtask

   // Owner 3 drops its request in its 2nd grant cycle; pending 5 follows
   task automatic test_drop();
      req = 8'h28;
      cyc();
      nvec++; if (grant !== 8'h08 || grant_idx !== 3'd3) begin nerr++; $display("FAIL drop_first: got %h/%0d want 08/3", grant, grant_idx); end
      cyc();
      nvec++; if (grant !== 8'h08) begin nerr++; $display("FAIL drop_second: got %h want 08", grant); end
      req = 8'h20;
      cyc();
      nvec++; if (grant !== 8'h00 || timeout !== 1'b0) begin nerr++; $display("FAIL drop_end: got %h/%b want 00/0", grant, timeout); end
      cyc();
      nvec++; if (grant !== 8'h20 || grant_idx !== 3'd5) begin nerr++; $display("FAIL drop_next: got %h/%0d want 20/5", grant, grant_idx); end
      req = 8'h00;
      cyc(); cyc();
   endtask

   // Release asserted while hold counter == MAX_HOLD: no timeout
   task automatic test_coincide();
      req = 8'h80;
      cyc();
      nvec++; if (grant !== 8'h80 || grant_idx !== 3'd7) begin nerr++; $display("FAIL co_grant: got %h/%0d want 80/7", grant, grant_idx); end
      cyc(); cyc(); cyc();
      nvec++; if (grant !== 8'h80) begin nerr++; $display("FAIL co_hold4: got %h want 80", grant); end
      rel = 1'b1;
      cyc();
      rel = 1'b0; req = 8'h00;
      nvec++; if (grant !== 8'h00 || timeout !== 1'b0) begin nerr++; $display("FAIL co_end: got %h/%b want 00/0", grant, timeout); end
      cyc();
      nvec++; if (timeout !== 1'b0) begin nerr++; $display("FAIL co_after: got %b want 0", timeout); end
   endtask

   // Reset in the middle of a grant to 5, then priority restarts at 0
   task automatic test_mid_reset();
      req = 8'h20;
      cyc();
      nvec++; if (grant !== 8'h20 || grant_idx !== 3'd5) begin nerr++; $display("FAIL mr_grant: got %h/%0d want 20/5", grant, grant_idx); end
      cyc();
      rst_n = 1'b0;
      cyc();
      nvec++; if (grant !== 8'h00 || grant_idx !== 3'd0 || grant_valid !== 1'b0 || timeout !== 1'b0)
         begin nerr++; $display("FAIL mr_reset: got %h/%0d/%b/%b want 00/0/0/0", grant, grant_idx, grant_valid, timeout); end
      rst_n = 1'b1; req = 8'h21;
      cyc();
      nvec++; if (grant !== 8'h01 || grant_idx !== 3'd0 || grant_valid !== 1'b1)
         begin nerr++; $display("FAIL mr_after: got %h/%0d/%b want 01/0/1", grant, grant_idx, grant_valid); end
      req = 8'h00;
      cyc();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_reset_priority();
      test_wrap();
      test_timeout();
      test_drop();
      test_coincide();
      test_mid_reset();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/rr_arbiter8.md
RR_ARBITER8 -- requirements
Module: rr_arbiter8

Interface
REQ-001 The module SHALL have parameter MAX_HOLD, default 16: the maximum number of cycles a grant may be held, range 1..255.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 The module SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-004 The module SHALL have port req, input, 8 bits: request per requester; bit i belongs to requester i.
REQ-005 The module SHALL have port release, input, 1 bit: pulse from the current owner that ends its grant.
REQ-006 The module SHALL have port grant, output, 8 bits: one-hot grant, registered.
REQ-007 The module SHALL have port grant_idx, output, 3 bits: binary index of the owner; valid only while grant_valid=1.
REQ-008 The module SHALL have port grant_valid, output, 1 bit: high exactly when grant is non-zero.
REQ-009 The module SHALL have port timeout, output, 1 bit: one-cycle pulse when a grant is revoked by MAX_HOLD.

Function
REQ-010 The module SHALL implement a two-state FSM: IDLE and GRANT.
REQ-011 In IDLE with req=0, the module SHALL stay in IDLE with grant=0.
REQ-012 In IDLE with req≠0, the module SHALL pick the first set bit scanning from (last_idx+1) mod 8 upward with wrap-around, and enter GRANT on the next edge.
REQ-013 On entering GRANT, the module SHALL register grant=one-hot(idx), grant_idx=idx and grant_valid=1.
REQ-014 The grant latency SHALL be one cycle from req sampled in IDLE to grant visible.
REQ-015 On entering GRANT, the module SHALL set last_idx to the granted index.
REQ-016 While in GRANT, the module SHALL increment an 8-bit hold counter each cycle, starting at 1 on the first grant cycle.
REQ-017 GRANT SHALL end on the next edge when any of these holds: release=1; req[grant_idx]=0; hold counter = MAX_HOLD.
REQ-018 When GRANT ends, the module SHALL go to IDLE with grant=0, grant_valid=0 and hold counter=0, giving at least one dead cycle between owners.
REQ-019 timeout SHALL pulse for one cycle, concurrent with the first dead cycle, only when the end was caused by the hold counter alone (release=0 and req[grant_idx]=1).
REQ-020 If release and timeout coincide, release SHALL take precedence and timeout SHALL stay 0.
REQ-021 In IDLE, release SHALL be ignored.
REQ-022 Requests from other requesters during GRANT SHALL be ignored until the next IDLE evaluation; there is no preemption.
REQ-023 After a grant to requester i, requester i SHALL have lowest priority in the next arbitration, guaranteeing each persistent requester a grant within 8 arbitrations.
REQ-024 grant SHALL never have more than one bit set.
REQ-025 grant_idx SHALL be held constant for the whole GRANT period.

Reset
REQ-026 When rst_n=0 at a clock edge, the module SHALL force state=IDLE, grant=0, grant_idx=0, grant_valid=0, timeout=0, hold counter=0 and last_idx=7, so that requester 0 has first priority.
REQ-027 A reset asserted mid-GRANT SHALL drop the grant on that same edge, and no timeout SHALL be generated.
REQ-028 The first arbitration SHALL happen in the first cycle after rst_n returns to 1.

Structure
REQ-029 The shared package SHALL hold the state encoding constants (IDLE=1'b0, GRANT=1'b1), the requester count (8) and the index width (3).
REQ-030 The index-to-one-hot conversion SHALL be a separate combinational sub-module, onehot_dec3to8 (3-bit in, 8-bit one-hot out, 000->0000_0001 ... 111->1000_0000), instantiated once.
REQ-031 The priority scan SHALL be combinational logic inside rr_arbiter8; the outputs SHALL be registered.

Verification
REQ-032 Bench scenario, reset priority: release reset, then req=8'hFF held -> grants to idx 0,1,2,...,7,0 in order, each ended by release, with one dead cycle between grants.
REQ-033 Bench scenario, wrap-around: last_idx=6, then req=8'b0100_0001 -> grant_idx=0, not 6.
REQ-034 Bench scenario, timeout: MAX_HOLD=4, req=8'h04 held and release=0 -> grant=8'h04 for exactly 4 cycles, then grant=0 with timeout=1 for one cycle, then re-grant to 2.
REQ-035 Bench scenario, request drop: owner 3 drops req[3] in the 2nd grant cycle -> grant=0 on the next edge, timeout=0, and pending req[5] is granted one cycle later.
REQ-036 Bench scenario, release/timeout coincidence: release=1 in the same cycle the hold counter equals MAX_HOLD -> grant ends and timeout stays 0.
REQ-037 Bench scenario, mid-grant reset: rst_n=0 during a grant to idx 5 -> all outputs are 0 at that edge; after reset, req=8'h21 -> grant_idx=0.
